uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver that deserialises the frame format produced by the team's UART transmitter: 1 start bit (low), 8 data bits LSB first, 1 even-parity bit (XOR of the 8 data bits), 1 stop bit (high). It sits between the asynchronous `rxd` pin and the register/FIFO logic in the `clk` domain. It derives bit timing internally from `CLOCK_RATE`/`BAUD_RATE`, samples each bit at its centre, and reports each byte with a one-cycle strobe and error flags.

## Interface
- `CLOCK_RATE`, 200_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate in bps; `BIT_CYCLES = CLOCK_RATE/BAUD_RATE` (integer division) must be >= 4.
- `clk`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `rxd`  input  1  asynchronous serial line; idle high.
- `data_out`  output  8  last received byte; held until the next frame completes.
- `rx_valid`  output  1  one-cycle strobe: `data_out`, `parity_err` and `frame_err` are updated this cycle.
- `parity_err`  output  1  received parity bit != ^data; updated with `rx_valid`.
- `frame_err`  output  1  stop bit sampled low; updated with `rx_valid`.
- `rx_busy`  output  1  high in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser (`rxd_s`), then a previous-value register `rxd_p`. All three reset to 0.
- A falling edge is `rxd_p==1 && rxd_s==0`. A line held low through reset therefore starts no frame until it has gone high.
- A bit counter `bit_cnt` runs from 0 to BIT_CYCLES-1, width `$clog2(BIT_CYCLES)`. `HALF = BIT_CYCLES/2`.
- The data index counts 0..7. The shift register fills LSB first: the first data bit lands in bit 0.
- State machine:
  - **IDLE**: `bit_cnt`=0. On a falling edge, go to START.
  - **START**: when `bit_cnt==HALF-1`, sample `rxd_s`. If it is 1 (glitch/false start), go to IDLE with no strobe. If it is 0, clear `bit_cnt` and go to DATA.
  - **DATA**: when `bit_cnt==BIT_CYCLES-1`, sample into `shift[idx]` and clear `bit_cnt`. After idx 7, go to PARITY.
  - **PARITY**: sample at `BIT_CYCLES-1`; store `par_err = sample ^ (^shift)`; go to STOP.
  - **STOP**: sample at `BIT_CYCLES-1`. On the next cycle, register `data_out<=shift`, `parity_err<=par_err`, `frame_err<=~sample`, and pulse `rx_valid` for 1 cycle. Then go to IDLE if the sample was 1, or to BREAK if it was 0.
  - **BREAK**: wait until `rxd_s==1`, then go to IDLE. No strobes are issued in this state.
- The byte is delivered even when a parity error or frame error occurs.
- Illegal state encodings return to IDLE.
- Reset values: `data_out`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `rx_busy`=0, state=IDLE.

## Timing
- Synchroniser latency: 2 cycles from a `rxd` change to `rxd_s`.
- Sample points, counted in cycles after the falling-edge detect cycle (cycle 0):
  - start bit: HALF;
  - data bit k: HALF + (k+1)·BIT_CYCLES;
  - parity bit: HALF + 9·BIT_CYCLES;
  - stop bit: HALF + 10·BIT_CYCLES.
- `rx_valid` is high exactly 1 cycle after the stop sample.
- `rx_busy` rises the cycle after the edge detect. It falls in the cycle `rx_valid` is high, or remains high through BREAK.
- A falling edge in the cycle after STOP returns to IDLE is accepted, so back-to-back frames are received with no lost byte.
- Receiver tolerance: the cumulative baud mismatch over a frame must stay within ±HALF cycles at the stop sample.
- Reset asserted mid-frame: all outputs clear asynchronously and no strobe is emitted for the aborted frame. After release, reception needs the line high, then a falling edge.

## Test plan
- Send 0xA5 with correct parity (0) at `CLOCK_RATE`=1_000_000, `BAUD_RATE`=62_500 (BIT_CYCLES=16) -> one `rx_valid`, `data_out`=0xA5, both error flags 0.
- Send 0x01 with the parity bit forced to 0 -> `data_out`=0x01, `parity_err`=1, `frame_err`=0.
- Send 0x3C with the stop bit low and the line held low for 40 cycles -> `frame_err`=1, `data_out`=0x3C, `rx_busy` stays high until the line returns high, no second strobe.
- Apply a 4-cycle low glitch on an idle line -> no `rx_valid`, state back in IDLE, `rx_busy` low within HALF+3 cycles.
- Send 0x00, 0xFF, 0x55 back-to-back with no idle gap, loop-connected to the team transmitter -> three strobes in order with matching data and no errors.
- Assert `rst_n` low mid-data of 0x81, then release with the line low -> no strobe. The next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART receiver: byte, strobe, error flags and busy.
// The receiver drives it through the master modport; consumers read it through slave.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output data_out,
        output rx_valid,
        output parity_err,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input data_out,
        input rx_valid,
        input parity_err,
        input frame_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, centre sampling.
// Bit timing is derived from CLOCK_RATE/BAUD_RATE; each byte is reported with a 1-cycle strobe.
module uart_rx #(
    parameter int CLOCK_RATE = 200_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rxd,
    uart_rx_if.master rx_if
);

    localparam int BIT_CYCLES = CLOCK_RATE / BAUD_RATE;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             rxd_meta_q;
    logic             rxd_s_q;
    logic             rxd_p_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             shift_we;
    logic             par_err_q, par_err_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;

    logic fall;
    logic cnt_last;
    logic cnt_mid;

    assign fall     = rxd_p_q & ~rxd_s_q;
    assign cnt_last = (bit_cnt_q == CNT_LAST);
    assign cnt_mid  = (bit_cnt_q == CNT_MID);

    // Synchroniser and edge-detect history reset to 0, so a line held low
    // through reset must go high before a start edge can be seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b0;
            rxd_s_q    <= 1'b0;
            rxd_p_q    <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rxd_p_q    <= rxd_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            idx_q        <= 3'd0;
            shift_q      <= 8'h00;
            par_err_q    <= 1'b0;
            data_out_q   <= 8'h00;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            data_out_q   <= data_out_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Each shift bit loads only when the data index points at it.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_d[gi] = (shift_we && (idx_q == 3'(gi))) ? rxd_s_q : shift_q[gi];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shift_we     = 1'b0;
        par_err_d    = par_err_q;
        data_out_d   = data_out_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_mid) begin
                    bit_cnt_d = '0;
                    idx_d     = 3'd0;
                    state_d   = rxd_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    bit_cnt_d = '0;
                    shift_we  = 1'b1;
                    idx_d     = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (cnt_last) begin
                    bit_cnt_d = '0;
                    par_err_d = rxd_s_q ^ (^shift_q);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_last) begin
                    // Registering here makes the strobe visible the cycle after the stop sample.
                    bit_cnt_d    = '0;
                    data_out_d   = shift_q;
                    parity_err_d = par_err_q;
                    frame_err_d  = ~rxd_s_q;
                    rx_valid_d   = 1'b1;
                    state_d      = rxd_s_q ? IDLE : BREAK;
                end
            end
            BREAK: begin
                bit_cnt_d = '0;
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    assign rx_if.data_out   = data_out_q;
    assign rx_if.rx_valid   = rx_valid_q;
    assign rx_if.parity_err = parity_err_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: directed frames push expectations,
// a monitor pops and compares on every rx_valid strobe, including strobe timing.
module tb_uart_rx;

    localparam int BC   = 16;
    localparam int HALF = BC / 2;
    // Strobe cycle relative to the negedge that drives the start bit low.
    localparam int STROBE_LAT = 3 + HALF + 10 * BC;

    logic clk;
    logic rst_n;
    logic rxd;
    int   cyc;
    int   tests;
    int   fails;
    int   strobes;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         at_cyc;
    } exp_t;

    exp_t sb_q[$];

    uart_rx_if rx_if ();

    uart_rx #(
        .CLOCK_RATE(1_000_000),
        .BAUD_RATE (62_500)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rxd  (rxd),
        .rx_if(rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expectation, at the predicted cycle.
    always @(negedge clk) begin
        if (rx_if.rx_valid === 1'b1) begin
            exp_t e;
            strobes++;
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_strobe: got data=%0h expected no strobe (cycle %0d)",
                         rx_if.data_out, cyc);
            end else begin
                e = sb_q.pop_front();
                check("data_out",   32'(rx_if.data_out),   32'(e.data));
                check("parity_err", 32'(rx_if.parity_err), 32'(e.perr));
                check("frame_err",  32'(rx_if.frame_err),  32'(e.ferr));
                check("strobe_cycle", 32'(cyc), 32'(e.at_cyc));
                check("busy_at_strobe", 32'(rx_if.rx_busy), 32'(e.ferr));
                $display("[TB] strobe data=%02h perr=%0b ferr=%0b cycle=%0d",
                         rx_if.data_out, rx_if.parity_err, rx_if.frame_err, cyc);
            end
        end
    end

    task automatic hold(input logic b, input int n);
        rxd = b;
        repeat (n) @(negedge clk);
    endtask

    // Transmitter model; assumes it is entered on a negedge and leaves on one.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic exp_perr, input logic exp_ferr);
        exp_t e;
        e.data   = d;
        e.perr   = exp_perr;
        e.ferr   = exp_ferr;
        e.at_cyc = cyc + STROBE_LAT;
        sb_q.push_back(e);
        $display("[TB] send data=%02h par=%0b stop=%0b", d, par, stop);
        hold(1'b0, BC);
        for (int i = 0; i < 8; i++) hold(d[i], BC);
        hold(par, BC);
        hold(stop, BC);
    endtask

    initial begin
        int s0;
        tests   = 0;
        fails   = 0;
        strobes = 0;
        rst_n   = 1'b0;
        rxd     = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_out",   32'(rx_if.data_out),   32'h00);
        check("reset_rx_valid",   32'(rx_if.rx_valid),   32'h0);
        check("reset_parity_err", 32'(rx_if.parity_err), 32'h0);
        check("reset_frame_err",  32'(rx_if.frame_err),  32'h0);
        check("reset_rx_busy",    32'(rx_if.rx_busy),    32'h0);
        rst_n = 1'b1;
        hold(1'b1, 2 * BC);

        // Clean byte, then a forced-wrong parity bit (0x01 has odd weight).
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(1'b1, BC);
        send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        hold(1'b1, BC);
        check("busy_after_parity_frame", 32'(rx_if.rx_busy), 32'h0);

        // Stop bit low, line held low: BREAK until the line recovers.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 40);
        check("busy_in_break",    32'(rx_if.rx_busy), 32'h1);
        check("strobes_in_break", 32'(strobes),       32'd3);
        hold(1'b1, 4);
        check("busy_after_break", 32'(rx_if.rx_busy), 32'h0);
        hold(1'b1, BC);

        // 4-cycle glitch: false start rejected at the mid-start sample.
        s0 = strobes;
        hold(1'b0, 4);
        check("busy_during_glitch", 32'(rx_if.rx_busy), 32'h1);
        hold(1'b1, HALF + 3 - 4);
        check("busy_after_glitch",    32'(rx_if.rx_busy), 32'h0);
        check("strobes_after_glitch", 32'(strobes),       32'(s0));
        hold(1'b1, BC);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 2 * BC);
        check("queue_empty_b2b", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of 0x81's data bits, released with the line low.
        s0 = strobes;
        $display("[TB] send data=81 aborted by reset");
        hold(1'b0, BC);
        hold(1'b1, BC);
        hold(1'b0, BC);
        hold(1'b0, HALF);
        rst_n = 1'b0;
        #1;
        check("midreset_data_out", 32'(rx_if.data_out), 32'h00);
        check("midreset_rx_busy",  32'(rx_if.rx_busy),  32'h0);
        check("midreset_rx_valid", 32'(rx_if.rx_valid), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 20);
        check("busy_low_line_after_reset", 32'(rx_if.rx_busy), 32'h0);
        hold(1'b1, 2 * BC);
        check("strobes_after_reset", 32'(strobes), 32'(s0));
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 2 * BC);

        check("queue_empty_final", 32'(sb_q.size()), 32'd0);
        check("total_strobes",     32'(strobes),     32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
